neuron_seq: RTL and testbench
=============================

Name: neuron_seq

Overview:
- Sequencer for one neuron datapath: weight/input memories -> multiplier -> `acc` (22-bit bias-preloaded accumulator).
- Evaluates NUM_NEURONS neurons of a layer one after another.
- For each neuron it issues NUM_IN input/weight addresses, drives the accumulator's bias-select (`acc_sel`) and capture-enable (`acc_en`) with the datapath latency aligned, and presents each result on a valid/ready handshake to the next layer or the argmax stage.
- Replaces the free-running accumulator control with start/busy/done layer sequencing.

Parameters:
- NUM_IN, 16: inputs (products) per neuron; must be >= 1.
- NUM_NEURONS, 10: neurons per layer; must be >= 1.
- LAT, 2: cycles from address issue to product at acc `din` (memory read + multiplier register); must be >= 1.
- IN_AW, 4: input address width, >= clog2(NUM_IN).
- N_AW, 4: neuron index width, >= clog2(NUM_NEURONS).
- W_AW, 8: weight address width, >= clog2(NUM_IN*NUM_NEURONS).

Ports:
- clk, input, 1: clock; all logic on rising edge.
- rst, input, 1: synchronous active-low reset.
- start, input, 1: begin layer evaluation; sampled only in IDLE.
- in_addr, output, IN_AW: input-vector read address k.
- w_addr, output, W_AW: weight read address, neuron*NUM_IN + k.
- addr_vld, output, 1: in_addr/w_addr valid this cycle.
- bias_addr, output, N_AW: bias ROM address (current neuron); held for the whole neuron.
- acc_sel, output, 1: 1 = accumulator adds bias instead of accReg (first product).
- acc_en, output, 1: 1 = accumulator dout captures sum (last product).
- res_valid, output, 1: acc dout holds the current neuron result.
- res_idx, output, N_AW: neuron index of the result.
- res_ready, input, 1: consumer accepts the result.
- busy, output, 1: high from start acceptance until done.
- done, output, 1: one-cycle pulse after the last result handshake.

Behaviour:
- Reset (rst=0 at an edge): FSM=IDLE; all outputs 0; counters and LAT-deep valid pipe cleared. Applies mid-operation and overrides every other input. The accumulator's own registers are not cleared by this block.
- States: IDLE, ISSUE, DRAIN, RESULT.
- IDLE:
  - start=1 -> ISSUE, neuron=0, k=0, busy=1.
  - start=0 -> stay.
- ISSUE:
  - addr_vld=1; in_addr=k; w_addr=neuron*NUM_IN+k.
  - w_addr is computed with a running base register (+NUM_IN per neuron), no multiplier.
  - k increments every cycle.
  - At k=NUM_IN-1 -> DRAIN; k=0 next.
  - Exactly NUM_IN consecutive issue cycles, no bubbles.
- Valid pipe: LAT-deep shift of {addr_vld, first(k=0), last(k=NUM_IN-1)}.
  - acc_sel = delayed first; acc_en = delayed last.
  - Both registered outputs, asserted exactly LAT cycles after the matching issue cycle.
  - NUM_IN=1: acc_sel and acc_en high in the same cycle.
- DRAIN: addr_vld=0; wait until delayed last has been output. In the cycle after acc_en -> RESULT with res_valid=1.
  - Timing: if start is sampled in cycle c, acc_sel is high in c+1+LAT, acc_en in c+LAT+NUM_IN, res_valid from c+LAT+NUM_IN+1.
- RESULT:
  - res_valid=1 and res_idx=neuron, held stable until res_ready=1.
  - On handshake (res_valid & res_ready), if neuron<NUM_NEURONS-1: neuron++, base+=NUM_IN, res_valid=0, -> ISSUE next cycle.
  - On handshake for the last neuron: -> IDLE, busy=0, done=1 for that one cycle.
  - res_ready while res_valid=0 is ignored.
  - No overlap between neurons: the accumulator's dout is stable until the handshake.
- bias_addr=neuron, updated on the handshake edge, so `b` is stable at least LAT cycles before acc_sel.
- start while busy is ignored. start in the done cycle is accepted, because the FSM is already in IDLE.
- Counter widths: k wraps only via an explicit compare, never natural overflow. No address exceeds NUM_IN*NUM_NEURONS-1.

Test Plan:
- Single layer, NUM_IN=4, NUM_NEURONS=3, LAT=2, res_ready tied 1, start pulse at cycle 0:
  - in_addr 0..3 in cycles 1-4; acc_sel high cycle 3; acc_en high cycle 6; res_valid cycle 7 with res_idx=0.
  - w_addr 4..7 for neuron 1, 8..11 for neuron 2; done exactly once; busy falls with done.
- Backpressure: res_ready=0 for 5 cycles on neuron 1 -> res_valid and res_idx=1 held; no addr_vld; bias_addr=1 stable; resumes 1 cycle after ready.
- Datapath check with the accumulator model, bias=-3 and products {10,20,30,40} -> result 97. No bias double-add between neurons (second neuron, bias 5, products all 1 -> 9).
- Edge config NUM_IN=1, LAT=1 -> acc_sel and acc_en in the same cycle; result = bias + p0.
- start held high throughout -> exactly one layer per IDLE visit. A second layer begins in the done cycle+1 with w_addr restarting at 0.
- rst=0 during ISSUE of neuron 1 -> next cycle all outputs 0, state IDLE. A fresh start then reproduces the first scenario's timing exactly.

Source files
------------

// File: rtl/neuron_seq_if.sv
// rtl/neuron_seq_if.sv - sequencer-to-datapath bus for one neuron layer
//
// Purpose: groups the memory address bus, the accumulator controls and the
// result handshake that connect neuron_seq to its datapath and consumer.
// Signals:
//   in_addr   - input-vector read address
//   w_addr    - weight read address
//   addr_vld  - in_addr/w_addr valid this cycle
//   bias_addr - bias ROM address (current neuron)
//   acc_sel   - accumulator adds bias instead of its own register
//   acc_en    - accumulator dout captures the sum
//   res_valid - accumulator dout holds the current neuron result
//   res_idx   - neuron index of the result
//   res_ready - consumer accepts the result
// Modports: master = sequencer side, slave = datapath/consumer side.
interface neuron_seq_if #(
  parameter int IN_AW = 4,
  parameter int N_AW  = 4,
  parameter int W_AW  = 8
) ();
  logic [IN_AW-1:0] in_addr;
  logic [W_AW-1:0]  w_addr;
  logic             addr_vld;
  logic [N_AW-1:0]  bias_addr;
  logic             acc_sel;
  logic             acc_en;
  logic             res_valid;
  logic [N_AW-1:0]  res_idx;
  logic             res_ready;

  modport master (
    output in_addr, w_addr, addr_vld, bias_addr, acc_sel, acc_en,
           res_valid, res_idx,
    input  res_ready
  );

  modport slave (
    input  in_addr, w_addr, addr_vld, bias_addr, acc_sel, acc_en,
           res_valid, res_idx,
    output res_ready
  );
endinterface

// File: rtl/neuron_seq.sv
// rtl/neuron_seq.sv - layer sequencer driving a bias-preloaded accumulator
//
// Purpose: on start, evaluates NUM_NEURONS neurons one after another. For each
// neuron it issues NUM_IN input/weight addresses back to back, raises acc_sel
// on the first product and acc_en on the last product (both LAT cycles after
// the matching address), then holds the result on a valid/ready handshake.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset
//   start - begin a layer (sampled only while idle)
//   busy  - high from start acceptance until done
//   done  - one-cycle pulse after the last result handshake
//   bus   - address, accumulator control and result handshake (master side)
module neuron_seq #(
  parameter int NUM_IN      = 16,
  parameter int NUM_NEURONS = 10,
  parameter int LAT         = 2,
  parameter int IN_AW       = 4,
  parameter int N_AW        = 4,
  parameter int W_AW        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  neuron_seq_if.master      bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} state_t;

  localparam logic [IN_AW-1:0] K_LAST    = IN_AW'(NUM_IN - 1);
  localparam logic [N_AW-1:0]  N_LAST    = N_AW'(NUM_NEURONS - 1);
  localparam logic [W_AW-1:0]  BASE_STEP = W_AW'(NUM_IN);

  state_t           state_q, state_d;
  logic [IN_AW-1:0] k_q, k_d;
  logic [N_AW-1:0]  neuron_q, neuron_d;
  logic [W_AW-1:0]  base_q, base_d;
  logic             done_q, done_d;
  // Delay line of {first, last} markers, qualified by the issue cycle.
  logic [1:0]       pipe_q [LAT];
  logic [1:0]       pipe_d [LAT];

  logic issue;
  logic k_last;
  logic handshake;
  logic delayed_first;
  logic delayed_last;

  always_comb begin
    issue         = (state_q == ISSUE);
    k_last        = (k_q == K_LAST);
    handshake     = (state_q == RESULT) && bus.res_ready;
    delayed_first = pipe_q[LAT-1][1];
    delayed_last  = pipe_q[LAT-1][0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (k_last) state_d = DRAIN;
      // The cycle after acc_en the accumulator dout holds the result.
      DRAIN:   if (delayed_last) state_d = RESULT;
      RESULT:  if (bus.res_ready) state_d = (neuron_q == N_LAST) ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.addr_vld  = issue;
    bus.in_addr   = issue ? k_q : '0;
    bus.w_addr    = issue ? (base_q + W_AW'(k_q)) : '0;
    bus.bias_addr = neuron_q;
    bus.acc_sel   = delayed_first;
    bus.acc_en    = delayed_last;
    bus.res_valid = (state_q == RESULT);
    bus.res_idx   = neuron_q;
    busy          = (state_q != IDLE);
    done          = done_q;
  end

  // Counters, weight base and marker pipe
  always_comb begin
    k_d      = k_q;
    neuron_d = neuron_q;
    base_d   = base_q;
    done_d   = 1'b0;

    if (issue) begin
      k_d = k_last ? '0 : k_q + IN_AW'(1);
    end

    if ((state_q == IDLE) && start) begin
      neuron_d = '0;
      base_d   = '0;
    end

    // bias_addr moves on the handshake edge, well ahead of the next acc_sel.
    if (handshake) begin
      if (neuron_q == N_LAST) begin
        done_d = 1'b1;
      end else begin
        neuron_d = neuron_q + N_AW'(1);
        base_d   = base_q + BASE_STEP;
      end
    end

    pipe_d[0] = {issue && (k_q == '0), issue && k_last};
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      k_q      <= '0;
      neuron_q <= '0;
      base_q   <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      k_q      <= k_d;
      neuron_q <= neuron_d;
      base_q   <= base_d;
      done_q   <= done_d;
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

endmodule

// File: tb/tb_neuron_seq.sv
// tb/tb_neuron_seq.sv - directed self-checking bench for neuron_seq
module tb_neuron_seq;

  logic clk;
  logic rst;
  logic start_m, busy_m, done_m;
  logic start_e, busy_e, done_e;
  int   total;
  int   bad;

  neuron_seq_if #(.IN_AW(2), .N_AW(2), .W_AW(4)) bus_m ();
  neuron_seq_if #(.IN_AW(1), .N_AW(1), .W_AW(1)) bus_e ();

  neuron_seq #(
    .NUM_IN(4), .NUM_NEURONS(3), .LAT(2), .IN_AW(2), .N_AW(2), .W_AW(4)
  ) u_main (
    .clk(clk), .rst(rst), .start(start_m), .busy(busy_m), .done(done_m),
    .bus(bus_m)
  );

  neuron_seq #(
    .NUM_IN(1), .NUM_NEURONS(2), .LAT(1), .IN_AW(1), .N_AW(1), .W_AW(1)
  ) u_edge (
    .clk(clk), .rst(rst), .start(start_e), .busy(busy_e), .done(done_e),
    .bus(bus_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: weight/input memories, LAT-stage product pipe, accumulator
  int w_m [16];
  int x_m [4];
  int b_m [4];
  int res_m [3];
  int p_m0, p_m1, acc_reg_m, acc_dout_m, acc_sum_m;

  int w_e [2];
  int x_e [2];
  int b_e [2];
  int res_e [2];
  int p_e0, acc_reg_e, acc_dout_e, acc_sum_e;

  always_comb acc_sum_m = (bus_m.acc_sel ? b_m[bus_m.bias_addr] : acc_reg_m) + p_m1;
  always_comb acc_sum_e = (bus_e.acc_sel ? b_e[bus_e.bias_addr] : acc_reg_e) + p_e0;

  always @(posedge clk) begin
    p_m0      <= bus_m.addr_vld ? w_m[bus_m.w_addr] * x_m[bus_m.in_addr] : 0;
    p_m1      <= p_m0;
    acc_reg_m <= acc_sum_m;
    if (bus_m.acc_en) acc_dout_m <= acc_sum_m;
    p_e0      <= bus_e.addr_vld ? w_e[bus_e.w_addr] * x_e[bus_e.in_addr] : 0;
    acc_reg_e <= acc_sum_e;
    if (bus_e.acc_en) acc_dout_e <= acc_sum_e;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] got_m;
    logic [9:0]  got_e;
    rst = 1'b0;
    step();
    step();
    got_m = {bus_m.addr_vld, bus_m.acc_sel, bus_m.acc_en, bus_m.res_valid, busy_m, done_m,
             bus_m.in_addr, bus_m.w_addr, bus_m.bias_addr, bus_m.res_idx};
    total++;
    if (got_m !== 20'd0) begin
      bad++;
      $display("FAIL reset_main got=%b want=0", got_m);
    end
    got_e = {bus_e.addr_vld, bus_e.acc_sel, bus_e.acc_en, bus_e.res_valid, busy_e, done_e,
             bus_e.in_addr, bus_e.w_addr, bus_e.bias_addr, bus_e.res_idx};
    total++;
    if (got_e !== 10'd0) begin
      bad++;
      $display("FAIL reset_edge got=%b want=0", got_e);
    end
    rst = 1'b1;
    step();
  endtask

  // Start at cycle 0 with res_ready=1: neuron n issues in cycles 1+7n..4+7n.
  task automatic test_single_layer(input string tag);
    logic [5:0] want, got;
    logic [1:0] want_in, want_idx;
    logic [3:0] want_w;
    int         want_res, b, n_done;
    n_done = 0;
    bus_m.res_ready = 1'b1;
    start_m = 1'b1;
    for (int cyc = 1; cyc <= 23; cyc++) begin
      step();
      if (cyc == 1) start_m = 1'b0;
      want     = {4'b0000, cyc <= 21, cyc == 22};
      want_in  = '0;
      want_w   = '0;
      want_idx = '0;
      want_res = 0;
      for (int n = 0; n < 3; n++) begin
        b = 1 + 7 * n;
        if (cyc >= b && cyc <= b + 3) begin
          want[5] = 1'b1;
          want_in = 2'(cyc - b);
          want_w  = 4'(4 * n + cyc - b);
        end
        if (cyc == b + 2) want[4] = 1'b1;
        if (cyc == b + 5) want[3] = 1'b1;
        if (cyc == b + 6) begin
          want[2]  = 1'b1;
          want_idx = 2'(n);
          want_res = res_m[n];
        end
      end
      got = {bus_m.addr_vld, bus_m.acc_sel, bus_m.acc_en, bus_m.res_valid, busy_m, done_m};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s ctrl cyc=%0d got=%b want=%b (vld,sel,en,rv,busy,done)", tag, cyc, got, want);
      end
      if (want[5]) begin
        total++;
        if ({bus_m.in_addr, bus_m.w_addr} !== {want_in, want_w}) begin
          bad++;
          $display("FAIL %s addr cyc=%0d got in=%0d w=%0d want in=%0d w=%0d",
                   tag, cyc, bus_m.in_addr, bus_m.w_addr, want_in, want_w);
        end
      end
      if (want[2]) begin
        total++;
        if (bus_m.res_idx !== want_idx || acc_dout_m != want_res) begin
          bad++;
          $display("FAIL %s result cyc=%0d got idx=%0d val=%0d want idx=%0d val=%0d",
                   tag, cyc, bus_m.res_idx, acc_dout_m, want_idx, want_res);
        end
      end
      if (cyc <= 21) begin
        total++;
        if (bus_m.bias_addr !== 2'((cyc - 1) / 7)) begin
          bad++;
          $display("FAIL %s bias_addr cyc=%0d got=%0d want=%0d", tag, cyc, bus_m.bias_addr, (cyc - 1) / 7);
        end
      end
      if (done_m === 1'b1) n_done++;
    end
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL %s done_count got=%0d want=1", tag, n_done);
    end
  endtask

  // Neuron 1 result appears at cycle 14; ready low until cycle 19.
  task automatic test_backpressure();
    logic [5:0] got;
    bus_m.res_ready = 1'b1;
    start_m = 1'b1;
    for (int cyc = 1; cyc <= 27; cyc++) begin
      step();
      if (cyc == 1) start_m = 1'b0;
      if (cyc == 8) bus_m.res_ready = 1'b0;
      if (cyc == 19) bus_m.res_ready = 1'b1;
      if (cyc >= 14 && cyc <= 19) begin
        got = {bus_m.res_valid, bus_m.addr_vld, bus_m.res_idx, bus_m.bias_addr};
        total++;
        if (got !== 6'b10_01_01 || acc_dout_m != 9) begin
          bad++;
          $display("FAIL bp_hold cyc=%0d got=%b val=%0d want=100101 val=9", cyc, got, acc_dout_m);
        end
      end
      if (cyc == 20) begin
        total++;
        if ({bus_m.res_valid, bus_m.addr_vld, bus_m.w_addr, bus_m.bias_addr} !== {1'b0, 1'b1, 4'd8, 2'd2}) begin
          bad++;
          $display("FAIL bp_resume cyc=20 got rv=%b vld=%b w=%0d bias=%0d want rv=0 vld=1 w=8 bias=2",
                   bus_m.res_valid, bus_m.addr_vld, bus_m.w_addr, bus_m.bias_addr);
        end
      end
      if (cyc == 26) begin
        total++;
        if (bus_m.res_valid !== 1'b1 || bus_m.res_idx !== 2'd2 || acc_dout_m != 108) begin
          bad++;
          $display("FAIL bp_last cyc=26 got rv=%b idx=%0d val=%0d want rv=1 idx=2 val=108",
                   bus_m.res_valid, bus_m.res_idx, acc_dout_m);
        end
      end
      if (cyc == 27) begin
        total++;
        if ({done_m, busy_m} !== 2'b10) begin
          bad++;
          $display("FAIL bp_done cyc=27 got done=%b busy=%b want done=1 busy=0", done_m, busy_m);
        end
      end
    end
  endtask

  task automatic test_start_held();
    int n_done, wait_cnt;
    n_done = 0;
    bus_m.res_ready = 1'b1;
    start_m = 1'b1;
    for (int cyc = 1; cyc <= 23; cyc++) begin
      step();
      if (cyc <= 22 && done_m === 1'b1) n_done++;
      if (cyc == 8) begin
        total++;
        if ({bus_m.addr_vld, bus_m.w_addr} !== {1'b1, 4'd4}) begin
          bad++;
          $display("FAIL held_no_restart cyc=8 got vld=%b w=%0d want vld=1 w=4", bus_m.addr_vld, bus_m.w_addr);
        end
      end
      if (cyc == 22) begin
        total++;
        if ({done_m, busy_m} !== 2'b10) begin
          bad++;
          $display("FAIL held_done cyc=22 got done=%b busy=%b want done=1 busy=0", done_m, busy_m);
        end
      end
      if (cyc == 23) begin
        total++;
        if ({bus_m.addr_vld, busy_m, bus_m.in_addr, bus_m.w_addr} !== {1'b1, 1'b1, 2'd0, 4'd0}) begin
          bad++;
          $display("FAIL held_second cyc=23 got vld=%b busy=%b in=%0d w=%0d want vld=1 busy=1 in=0 w=0",
                   bus_m.addr_vld, busy_m, bus_m.in_addr, bus_m.w_addr);
        end
      end
    end
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL held_done_count got=%0d want=1", n_done);
    end
    start_m = 1'b0;
    wait_cnt = 0;
    while (done_m !== 1'b1 && wait_cnt < 40) begin
      step();
      wait_cnt++;
    end
    total++;
    if (done_m !== 1'b1) begin
      bad++;
      $display("FAIL held_second_done got=timeout want=done within 40 cycles");
    end
    step();
    total++;
    if (busy_m !== 1'b0) begin
      bad++;
      $display("FAIL held_stop got busy=%b want busy=0", busy_m);
    end
  endtask

  // NUM_IN=1, LAT=1: neuron n issues at 1+3n, sel/en at 2+3n, result at 3+3n.
  task automatic test_edge_config();
    logic [5:0] want, got;
    int b;
    bus_e.res_ready = 1'b1;
    start_e = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      step();
      if (cyc == 1) start_e = 1'b0;
      want = {4'b0000, cyc <= 6, cyc == 7};
      for (int n = 0; n < 2; n++) begin
        b = 1 + 3 * n;
        if (cyc == b) begin
          want[5] = 1'b1;
          total++;
          if (bus_e.w_addr !== 1'(n) || bus_e.in_addr !== 1'b0) begin
            bad++;
            $display("FAIL edge_addr cyc=%0d got w=%0d in=%0d want w=%0d in=0", cyc, bus_e.w_addr, bus_e.in_addr, n);
          end
        end
        if (cyc == b + 1) want[4:3] = 2'b11;
        if (cyc == b + 2) begin
          want[2] = 1'b1;
          total++;
          if (bus_e.res_idx !== 1'(n) || acc_dout_e != res_e[n]) begin
            bad++;
            $display("FAIL edge_result cyc=%0d got idx=%0d val=%0d want idx=%0d val=%0d",
                     cyc, bus_e.res_idx, acc_dout_e, n, res_e[n]);
          end
        end
      end
      got = {bus_e.addr_vld, bus_e.acc_sel, bus_e.acc_en, bus_e.res_valid, busy_e, done_e};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL edge_ctrl cyc=%0d got=%b want=%b (vld,sel,en,rv,busy,done)", cyc, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [19:0] got;
    bus_m.res_ready = 1'b1;
    start_m = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      step();
      if (cyc == 1) start_m = 1'b0;
    end
    total++;
    if ({bus_m.addr_vld, bus_m.bias_addr} !== {1'b1, 2'd1}) begin
      bad++;
      $display("FAIL midrst_pre cyc=9 got vld=%b bias=%0d want vld=1 bias=1", bus_m.addr_vld, bus_m.bias_addr);
    end
    rst = 1'b0;
    step();
    got = {bus_m.addr_vld, bus_m.acc_sel, bus_m.acc_en, bus_m.res_valid, busy_m, done_m,
           bus_m.in_addr, bus_m.w_addr, bus_m.bias_addr, bus_m.res_idx};
    total++;
    if (got !== 20'd0) begin
      bad++;
      $display("FAIL midrst_outputs got=%b want=0", got);
    end
    rst = 1'b1;
    test_single_layer("restart");
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    start_m = 1'b0;
    start_e = 1'b0;
    bus_m.res_ready = 1'b1;
    bus_e.res_ready = 1'b1;
    for (int i = 0; i < 16; i++) w_m[i] = 0;
    w_m[0] = 10; w_m[1] = 20; w_m[2] = 30; w_m[3] = 40;
    for (int i = 4; i < 8; i++) w_m[i] = 1;
    for (int i = 8; i < 12; i++) w_m[i] = 2;
    for (int i = 0; i < 4; i++) x_m[i] = 1;
    b_m[0] = -3; b_m[1] = 5; b_m[2] = 100; b_m[3] = 0;
    res_m[0] = 97; res_m[1] = 9; res_m[2] = 108;
    w_e[0] = 6; w_e[1] = 11;
    x_e[0] = 2; x_e[1] = 0;
    b_e[0] = 7; b_e[1] = -2;
    res_e[0] = 19; res_e[1] = 20;

    test_reset();
    test_single_layer("layer");
    test_backpressure();
    test_start_held();
    test_edge_config();
    test_reset_mid_op();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
